// File: rtl/brq_tlul_host_mo.sv
`default_nettype none
// ============================================================================
// Module   : brq_tlul_host_mo
// Brief    : TL-UL host adapter for the brq_core req/gnt/rvalid memory port.
//            Up to MaxReqs outstanding transactions, in-order delivery of
//            out-of-order D responses through a per-slot reorder buffer.
// Revision : 1.0 - initial release
// ============================================================================
module brq_tlul_host_mo #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MaxReqs = 4,
    parameter int SourceW = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    output logic               gnt_o,
    input  logic [AW-1:0]      addr_i,
    input  logic               we_i,
    input  logic [DW-1:0]      wdata_i,
    input  logic [DW/8-1:0]    be_i,
    output logic               valid_o,
    output logic [DW-1:0]      rdata_o,
    output logic               err_o,
    output logic               proto_err_o,
    output logic               a_valid_o,
    input  logic               a_ready_i,
    output logic [2:0]         a_opcode_o,
    output logic [1:0]         a_size_o,
    output logic [AW-1:0]      a_address_o,
    output logic [DW/8-1:0]    a_mask_o,
    output logic [DW-1:0]      a_data_o,
    output logic [SourceW-1:0] a_source_o,
    input  logic               d_valid_i,
    output logic               d_ready_o,
    input  logic [SourceW-1:0] d_source_i,
    input  logic [DW-1:0]      d_data_i,
    input  logic               d_error_i
);

    localparam int BW  = DW / 8;
    localparam int OFF = $clog2(BW);
    localparam int IW  = (MaxReqs > 1) ? $clog2(MaxReqs) : 1;
    localparam int CW  = $clog2(MaxReqs + 1);

    localparam logic [IW-1:0]    C_LAST_SLOT = IW'(MaxReqs - 1);
    localparam logic [CW-1:0]    C_FULL      = CW'(MaxReqs);
    localparam logic [SourceW:0] C_SRC_LIMIT = (SourceW + 1)'(MaxReqs);
    localparam logic [2:0]       C_OP_PUTFULL = 3'd0;
    localparam logic [2:0]       C_OP_PUTPART = 3'd1;
    localparam logic [2:0]       C_OP_GET     = 3'd4;

    logic [MaxReqs-1:0] alloc_q, alloc_d;
    logic [MaxReqs-1:0] done_q,  done_d;
    logic [MaxReqs-1:0] we_q,    we_d;
    logic [MaxReqs-1:0] err_q,   err_d;
    logic [DW-1:0]      data_q [MaxReqs];
    logic [DW-1:0]      data_d [MaxReqs];
    logic [IW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [IW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q,  count_d;
    logic               proto_err_q, proto_err_d;

    logic          full;
    logic          d_fire;
    logic          d_legal;
    logic [IW-1:0] d_slot;

    // Fullness uses the registered count, so a same-cycle delivery never unblocks issue.
    assign full        = (count_q == C_FULL);
    assign a_valid_o   = req_i & ~full & ~rst_i;
    assign gnt_o       = a_valid_o & a_ready_i;
    assign a_source_o  = SourceW'(wr_ptr_q);
    assign a_opcode_o  = ~we_i ? C_OP_GET : (&be_i ? C_OP_PUTFULL : C_OP_PUTPART);
    assign a_size_o    = 2'(OFF);
    assign a_address_o = {addr_i[AW-1:OFF], {OFF{1'b0}}};
    assign a_mask_o    = we_i ? be_i : {BW{1'b1}};
    assign a_data_o    = wdata_i;

    assign d_ready_o   = ~rst_i;
    assign d_fire      = d_valid_i & d_ready_o;
    assign d_slot      = d_source_i[IW-1:0];
    assign d_legal     = d_fire && ({1'b0, d_source_i} < C_SRC_LIMIT)
                         && alloc_q[d_slot] && !done_q[d_slot];

    assign valid_o     = alloc_q[rd_ptr_q] & done_q[rd_ptr_q] & ~rst_i;
    assign err_o       = err_q[rd_ptr_q];
    assign rdata_o     = (we_q[rd_ptr_q] | err_q[rd_ptr_q]) ? '0 : data_q[rd_ptr_q];
    assign proto_err_o = proto_err_q & ~rst_i;

    always_comb begin
        alloc_d  = alloc_q;
        done_d   = done_q;
        we_d     = we_q;
        err_d    = err_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (valid_o) begin
            alloc_d[rd_ptr_q] = 1'b0;
            done_d[rd_ptr_q]  = 1'b0;
            rd_ptr_d          = (rd_ptr_q == C_LAST_SLOT) ? '0 : rd_ptr_q + 1'b1;
        end
        if (gnt_o) begin
            alloc_d[wr_ptr_q] = 1'b1;
            done_d[wr_ptr_q]  = 1'b0;
            we_d[wr_ptr_q]    = we_i;
            wr_ptr_d          = (wr_ptr_q == C_LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
        end
        // Legality was judged on registered state, so this never hits a slot freed this cycle.
        if (d_legal) begin
            done_d[d_slot] = 1'b1;
            data_d[d_slot] = d_data_i;
            err_d[d_slot]  = d_error_i;
        end

        count_d     = count_q + CW'(gnt_o) - CW'(valid_o);
        proto_err_d = d_fire & ~d_legal;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alloc_q     <= '0;
            done_q      <= '0;
            we_q        <= '0;
            err_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < MaxReqs; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            alloc_q     <= alloc_d;
            done_q      <= done_d;
            we_q        <= we_d;
            err_q       <= err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            proto_err_q <= proto_err_d;
            for (int i = 0; i < MaxReqs; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule
`default_nettype wire
